// File: rtl/fp_operand_fifo_if.sv
// Handshake and operand bus for fp_operand_fifo: producer side (IN_*, A/B
// fields) and consumer side (OUT_*, A1/B1 fields) grouped in one bundle.
interface fp_operand_fifo_if #(
  parameter int MW = 24,
  parameter int EW = 8
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [MW-1:0] A;
  logic [MW-1:0] B;
  logic [EW-1:0] AE;
  logic [EW-1:0] BE;
  logic          AS;
  logic          BS;

  logic          OUT_VALID;
  logic          OUT_READY;
  logic [MW-1:0] A1;
  logic [MW-1:0] B1;
  logic [EW-1:0] AE1;
  logic [EW-1:0] BE1;
  logic          AS1;
  logic          BS1;

  // FIFO side
  modport slave (
    input  IN_VALID, A, B, AE, BE, AS, BS, OUT_READY,
    output IN_READY, OUT_VALID, A1, B1, AE1, BE1, AS1, BS1
  );

  // Producer/consumer side
  modport master (
    output IN_VALID, A, B, AE, BE, AS, BS, OUT_READY,
    input  IN_READY, OUT_VALID, A1, B1, AE1, BE1, AS1, BS1
  );
endinterface

// File: rtl/fp_operand_fifo.sv
// Operand-pair FIFO: stores {AS,AE,A,BS,BE,B} unmodified, DEPTH entries,
// registered-only ready/valid, flush has priority over push and pop.
module fp_operand_fifo #(
  parameter int MW    = 24,
  parameter int EW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       FLUSH,
  fp_operand_fifo_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);
  localparam int ENT_W = 2 * (1 + EW + MW);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_wr_entry;
  logic [ENT_W-1:0] w_rd_entry;

  // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.IN_VALID & w_in_ready;
  assign w_pop       = w_out_valid & bus.OUT_READY;
  assign w_wr_entry  = {bus.AS, bus.AE, bus.A, bus.BS, bus.BE, bus.B};
  assign w_rd_entry  = r_mem[r_rd_ptr];

  // Entry storage: cleared by reset and flush, written on push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = w_out_valid;
  assign {bus.AS1, bus.AE1, bus.A1, bus.BS1, bus.BE1, bus.B1} = w_rd_entry;
  assign COUNT = r_count;
endmodule

// File: tb/tb_fp_operand_fifo.sv
// Bench for fp_operand_fifo: queue-based model checked every cycle, plus
// directed literal checks. DEPTH=4 instance for most cases, DEPTH=3 for the
// continuous stream with pointer wrap.
module tb_fp_operand_fifo;
  typedef logic [65:0] ent_t;

  logic       CLK;
  logic       RST_N;
  logic       flush4;
  logic       flush3;
  logic [2:0] cnt4;
  logic [1:0] cnt3;

  int n_err    = 0;
  int n_checks = 0;
  int n4, n3;

  ent_t q4[$];
  ent_t q3[$];

  fp_operand_fifo_if #(.MW(24), .EW(8)) if4 ();
  fp_operand_fifo_if #(.MW(24), .EW(8)) if3 ();

  fp_operand_fifo #(.MW(24), .EW(8), .DEPTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(flush4), .bus(if4.slave), .COUNT(cnt4)
  );
  fp_operand_fifo #(.MW(24), .EW(8), .DEPTH(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(flush3), .bus(if3.slave), .COUNT(cnt3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int i);
    return {1'b0, 8'(i + 1), 24'(32'h100000 * (i + 1)), 1'b1, 8'(8'h40 + i), 24'(32'h0A0000 + i)};
  endfunction

  function automatic ent_t head4();
    return {if4.AS1, if4.AE1, if4.A1, if4.BS1, if4.BE1, if4.B1};
  endfunction

  function automatic ent_t head3();
    return {if3.AS1, if3.AE1, if3.A1, if3.BS1, if3.BE1, if3.B1};
  endfunction

  task automatic drv4(input logic v, input ent_t e, input logic ordy, input logic fl);
    if4.IN_VALID = v;
    {if4.AS, if4.AE, if4.A, if4.BS, if4.BE, if4.B} = e;
    if4.OUT_READY = ordy;
    flush4 = fl;
  endtask

  task automatic drv3(input logic v, input ent_t e, input logic ordy);
    if3.IN_VALID = v;
    {if3.AS, if3.AE, if3.A, if3.BS, if3.BE, if3.B} = e;
    if3.OUT_READY = ordy;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference model, DEPTH=4: plain FIFO queue.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q4.delete();
    else if (flush4) q4.delete();
    else begin
      n4 = q4.size();
      if (if4.OUT_READY && n4 > 0) void'(q4.pop_front());
      if (if4.IN_VALID && n4 < 4)
        q4.push_back({if4.AS, if4.AE, if4.A, if4.BS, if4.BE, if4.B});
    end
  end

  // Reference model, DEPTH=3.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q3.delete();
    else if (flush3) q3.delete();
    else begin
      n3 = q3.size();
      if (if3.OUT_READY && n3 > 0) void'(q3.pop_front());
      if (if3.IN_VALID && n3 < 3)
        q3.push_back({if3.AS, if3.AE, if3.A, if3.BS, if3.BE, if3.B});
    end
  end

  // Every-cycle comparison of both DUTs against the models.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("m4_count", 66'(cnt4), 66'(q4.size()));
      chk("m4_in_ready", 66'(if4.IN_READY), 66'(q4.size() < 4));
      chk("m4_out_valid", 66'(if4.OUT_VALID), 66'(q4.size() != 0));
      if (q4.size() > 0) chk("m4_head", head4(), q4[0]);
      chk("m3_count", 66'(cnt3), 66'(q3.size()));
      chk("m3_in_ready", 66'(if3.IN_READY), 66'(q3.size() < 3));
      chk("m3_out_valid", 66'(if3.OUT_VALID), 66'(q3.size() != 0));
      if (q3.size() > 0) chk("m3_head", head3(), q3[0]);
    end
  end

  initial begin
    ent_t e1;
    e1 = {1'b0, 8'h7F, 24'h800000, 1'b1, 8'h80, 24'hC00000};
    RST_N = 1'b0;
    drv4(1'b0, '0, 1'b0, 1'b0);
    drv3(1'b0, '0, 1'b0);
    flush3 = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset state
    chk("rst_count", 66'(cnt4), 66'd0);
    chk("rst_in_ready", 66'(if4.IN_READY), 66'd1);
    chk("rst_out_valid", 66'(if4.OUT_VALID), 66'd0);
    chk("rst_fields", head4(), 66'd0);

    // Single pass, first edge after release accepts the push
    RST_N = 1'b1;
    drv4(1'b1, e1, 1'b1, 1'b0);
    step();
    chk("single_valid", 66'(if4.OUT_VALID), 66'd1);
    chk("single_fields", head4(), e1);
    chk("single_count", 66'(cnt4), 66'd1);
    drv4(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("single_count_after", 66'(cnt4), 66'd0);

    // Fill with 5 pairs, consumer stalled
    for (int i = 0; i < 5; i++) begin
      drv4(1'b1, mk(i), 1'b0, 1'b0);
      step();
      if (i == 3) begin
        chk("fill_count4", 66'(cnt4), 66'd4);
        chk("fill_in_ready", 66'(if4.IN_READY), 66'd0);
      end
    end
    chk("fill_count5", 66'(cnt4), 66'd4);

    // Full with pop: offered pair dropped
    chk("full_head", head4(), mk(0));
    drv4(1'b1, mk(5), 1'b1, 1'b0);
    step();
    chk("fullpop_count", 66'(cnt4), 66'd3);
    drv4(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      chk("drain_order", head4(), mk(i));
      step();
    end
    chk("drain_empty", 66'(cnt4), 66'd0);
    chk("drain_out_valid", 66'(if4.OUT_VALID), 66'd0);

    // Flush with a concurrent push
    for (int i = 30; i < 33; i++) begin
      drv4(1'b1, mk(i), 1'b0, 1'b0);
      step();
    end
    chk("flush_pre_count", 66'(cnt4), 66'd3);
    drv4(1'b1, mk(33), 1'b0, 1'b1);
    step();
    drv4(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", 66'(cnt4), 66'd0);
    chk("flush_out_valid", 66'(if4.OUT_VALID), 66'd0);
    chk("flush_in_ready", 66'(if4.IN_READY), 66'd1);

    // Async reset between edges with two entries held
    for (int i = 40; i < 42; i++) begin
      drv4(1'b1, mk(i), 1'b0, 1'b0);
      step();
    end
    drv4(1'b0, '0, 1'b0, 1'b0);
    chk("arst_pre_count", 66'(cnt4), 66'd2);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_count", 66'(cnt4), 66'd0);
    chk("arst_out_valid", 66'(if4.OUT_VALID), 66'd0);
    chk("arst_fields", head4(), 66'd0);
    drv4(1'b1, mk(50), 1'b1, 1'b0);
    step();
    chk("arst_edge_blocked", 66'(cnt4), 66'd0);
    RST_N = 1'b1;
    step();
    chk("rel_push", 66'(cnt4), 66'd1);
    chk("rel_head", head4(), mk(50));
    drv4(1'b0, '0, 1'b1, 1'b0);
    step();

    // Continuous stream through DEPTH=3 with wrap
    for (int i = 0; i < 20; i++) begin
      drv3(1'b1, mk(100 + i), 1'b1);
      step();
      chk("stream_count", 66'(cnt3), 66'd1);
      chk("stream_head", head3(), mk(100 + i));
    end
    drv3(1'b0, '0, 1'b1);
    step();
    chk("stream_end_count", 66'(cnt3), 66'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fp_operand_fifo.md
FP_OPERAND_FIFO -- requirements
Module: fp_operand_fifo

Interface
REQ-001 The block SHALL take parameter MW, default 24: mantissa width of each operand.
REQ-002 The block SHALL take parameter EW, default 8: exponent width of each operand.
REQ-003 The block SHALL take parameter DEPTH, default 4: number of operand-pair entries; legal range 2..16.
REQ-004 The block SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port FLUSH  input  1  synchronous clear of all entries.
REQ-007 The block SHALL have port IN_VALID  input  1  producer offers an operand pair.
REQ-008 The block SHALL have port IN_READY  output  1  block can accept a pair this cycle.
REQ-009 The block SHALL have ports A, B  input  MW each  operand mantissas.
REQ-010 The block SHALL have ports AE, BE  input  EW each  operand exponents.
REQ-011 The block SHALL have ports AS, BS  input  1 each  operand signs.
REQ-012 The block SHALL have port OUT_VALID  output  1  head entry is valid.
REQ-013 The block SHALL have port OUT_READY  input  1  consumer takes head entry this cycle.
REQ-014 The block SHALL have ports A1, B1 (MW), AE1, BE1 (EW), AS1, BS1 (1)  output  head-entry fields.
REQ-015 The block SHALL have port COUNT  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 The block SHALL store each entry as the packed field set {AS,AE,A,BS,BE,B}, 2*(1+EW+MW) bits, unmodified.
REQ-017 The block SHALL perform a push on a rising edge when IN_VALID=1 and IN_READY=1, writing at the write pointer.
REQ-018 The block SHALL perform a pop on a rising edge when OUT_VALID=1 and OUT_READY=1, advancing the read pointer.
REQ-019 The block SHALL drive IN_READY = (COUNT < DEPTH), combinationally from registered state only; no dependence on OUT_READY.
REQ-020 The block SHALL drive OUT_VALID = (COUNT != 0), from registered state only.
REQ-021 The block SHALL drive A1..BS1 from the entry at the read pointer; fields are don't-care-free: they show the stored entry even when OUT_VALID=0.
REQ-022 The block SHALL have latency 1: a pair pushed at edge k appears on A1..BS1 with OUT_VALID=1 after edge k when the FIFO was empty; no same-cycle bypass.
REQ-023 The block SHALL wrap both pointers from DEPTH-1 to 0, including non-power-of-2 DEPTH.
REQ-024 The block SHALL, on simultaneous push and pop, write and read in the same edge and leave COUNT unchanged.
REQ-025 The block SHALL, when full (COUNT=DEPTH), hold IN_READY=0 and ignore IN_VALID, even if a pop occurs that edge.
REQ-026 The block SHALL, when empty, ignore OUT_READY; COUNT never underflows or exceeds DEPTH.
REQ-027 The block SHALL give FLUSH priority over push and pop: at the edge with FLUSH=1, pointers and COUNT go to 0 and any concurrent push is discarded.
REQ-028 The block SHALL preserve entry order exactly (first in, first out) across wrap-around and back-pressure.

Reset
REQ-029 The block SHALL, on RST_N=0, immediately and asynchronously set pointers and COUNT to 0 and clear all storage to 0.
REQ-030 The block SHALL present during and after reset: IN_READY=1, OUT_VALID=0, COUNT=0, A1..BS1=0.
REQ-031 The block SHALL treat reset asserted mid-transfer as dominant; no push or pop completes on an edge with RST_N=0.
REQ-032 The block SHALL release reset synchronously safe: first push possible on the first rising edge with RST_N=1.

Verification
REQ-033 Single pass (DEPTH=4): push A=24'h800000,AE=8'h7F,AS=0,B=24'hC00000,BE=8'h80,BS=1 with OUT_READY=1 -> next cycle OUT_VALID=1, fields equal, COUNT=1; following cycle COUNT=0.
REQ-034 Fill: push 5 distinct pairs with OUT_READY=0 -> COUNT=4, IN_READY=0 after 4th edge, 5th pair not stored; drain yields pairs 1..4 in order.
REQ-035 Full with pop: COUNT=4, IN_VALID=1, OUT_READY=1 for one edge -> COUNT=3, offered pair not stored.
REQ-036 Steady stream: 20 pairs, IN_VALID=1 and OUT_READY=1 throughout with DEPTH=3 -> COUNT stays 1, all 20 pairs out in order, pointers wrap.
REQ-037 Flush: COUNT=3, FLUSH=1 with IN_VALID=1 -> next cycle COUNT=0, OUT_VALID=0, IN_READY=1.
REQ-038 Async reset: assert RST_N=0 between edges with COUNT=2 -> COUNT=0, OUT_VALID=0, A1..BS1=0 before next edge.
